// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable width, divider, runtime CPOL/CPHA and chip select.
// One transfer at a time via a start/busy/done handshake; all SPI pins are registered.
module spi_master_multi #(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 4,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DATA_W-1:0] tdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TOG_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_XFER, ST_TRAIL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOG_W-1:0]    tog_q, tog_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mosi_q, mosi_d;
  logic                sck_q, sck_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;

  logic                tick;
  logic [TOG_W-1:0]    tog_nx;
  logic                leading;
  logic                sample_edge;
  logic                drive_edge;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // An out-of-range index leaves every line deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign tick    = (cnt_q == CNT_LAST);
  assign tog_nx  = tog_q + TOG_W'(1);
  // Odd toggles move SCK away from its idle level.
  assign leading = tog_nx[0];
  assign sample_edge = (leading != cpha_q);
  assign drive_edge  = cpha_q ? leading : (!leading && (tog_nx != TOG_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    tog_d   = tog_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    mosi_d  = mosi_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    if (state_q != ST_IDLE && !tick) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LEAD;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          sck_d   = cpol_i;
          cs_n_d  = cs_decode(cs_sel_i);
          busy_d  = 1'b1;
          tog_d   = '0;
          rx_d    = '0;
          // With cpha=0 the first bit must already be valid when CS falls.
          if (!cpha_i) begin
            mosi_d = head_bit(tdata_i);
            tx_d   = shift_out(tdata_i);
          end else begin
            tx_d   = tdata_i;
          end
        end
      end
      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          tog_d = tog_nx;
          sck_d = ~sck_q;
          if (sample_edge) rx_d = shift_in(rx_q, miso_i);
          if (drive_edge) begin
            mosi_d = head_bit(tx_q);
            tx_d   = shift_out(tx_q);
          end
          if (tog_nx == TOG_LAST) state_d = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = '1;
          rdata_d = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end

  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sck_o   = sck_q;
  assign mosi_o  = mosi_q;
  assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: an 8-bit MSB-first instance with a behavioural slave,
// and a 16-bit LSB-first, divider-1, three-select instance in loopback.
module tb_spi_master_multi;

  localparam int LAT_A = (2 * 8 + 2) * 4 + 1;
  localparam int LAT_B = (2 * 16 + 2) * 1 + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       start_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0, loop_a = 1'b1, sl_miso = 1'b0;
  logic [1:0] cs_sel_a = '0;
  logic [7:0] tdata_a = '0;
  logic [7:0] rdata_a;
  logic       busy_a, done_a, sck_a, mosi_a, miso_a;
  logic [3:0] cs_n_a;
  assign miso_a = loop_a ? mosi_a : sl_miso;

  logic        start_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0;
  logic [1:0]  cs_sel_b = '0;
  logic [15:0] tdata_b = '0;
  logic [15:0] rdata_b;
  logic        busy_b, done_b, sck_b, mosi_b, miso_b;
  logic [2:0]  cs_n_b;
  assign miso_b = mosi_b;

  spi_master_multi #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .cs_sel_i(cs_sel_a), .cpol_i(cpol_a),
    .cpha_i(cpha_a), .tdata_i(tdata_a), .rdata_o(rdata_a), .busy_o(busy_a), .done_o(done_a),
    .sck_o(sck_a), .mosi_o(mosi_a), .miso_i(miso_a), .cs_n_o(cs_n_a));

  spi_master_multi #(.DATA_W(16), .NUM_CS(3), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .cs_sel_i(cs_sel_b), .cpol_i(cpol_b),
    .cpha_i(cpha_b), .tdata_i(tdata_b), .rdata_o(rdata_b), .busy_o(busy_b), .done_o(done_b),
    .sck_o(sck_b), .mosi_o(mosi_b), .miso_i(miso_b), .cs_n_o(cs_n_b));

  // Drives one transfer on instance A and observes the SPI pins once per cycle on the
  // falling clock edge, acting as an MSB-first slave that returns sw when loop=0.
  task automatic xfer_a(input logic [7:0] td, input logic pol, input logic pha,
                        input logic [1:0] sel, input logic loop, input logic [7:0] sw,
                        input bit nowait, input int poke, input int stop_bits,
                        output int lat, output logic [7:0] rd, output logic busy1,
                        output logic [7:0] got, output int nbits, output int rises,
                        output logic [3:0] cs_or);
    logic prev, lead;
    int idx;
    bit fin;
    if (!nowait) @(negedge clk);
    start_a = 1'b1; tdata_a = td; cpol_a = pol; cpha_a = pha; cs_sel_a = sel; loop_a = loop;
    @(negedge clk);
    start_a = 1'b0; tdata_a = ~td; cpol_a = ~pol; cpha_a = ~pha; cs_sel_a = sel + 2'd1;
    busy1 = busy_a; lat = 1; got = '0; nbits = 0; rises = 0; cs_or = '0; idx = 0;
    prev = sck_a; fin = 1'b0;
    if (!pha) begin sl_miso = sw[7]; idx = 1; end
    while (!fin) begin
      cs_or |= ~cs_n_a;
      if (sck_a !== prev) begin
        lead = (sck_a !== pol);
        if (sck_a === 1'b1) rises++;
        if (lead !== pha) begin
          got = {got[6:0], mosi_a};
          nbits++;
        end else if (idx < 8) begin
          sl_miso = sw[7 - idx];
          idx++;
        end
      end
      prev = sck_a;
      if (done_a === 1'b1 || lat >= 400 || (stop_bits > 0 && nbits >= stop_bits)) begin
        fin = 1'b1;
      end else begin
        start_a = (lat == poke);
        @(negedge clk);
        lat++;
      end
    end
    start_a = 1'b0;
    rd = rdata_a;
  endtask

  // Instance B is always in loopback; bits are collected first-to-LSB.
  task automatic xfer_b(input logic [15:0] td, input logic pol, input logic pha,
                        input logic [1:0] sel, output int lat, output logic [15:0] rd,
                        output logic [15:0] got, output int nbits, output logic [2:0] cs_or);
    logic prev;
    bit fin;
    @(negedge clk);
    start_b = 1'b1; tdata_b = td; cpol_b = pol; cpha_b = pha; cs_sel_b = sel;
    @(negedge clk);
    start_b = 1'b0; tdata_b = ~td; cpol_b = ~pol; cpha_b = ~pha; cs_sel_b = sel + 2'd1;
    lat = 1; got = '0; nbits = 0; cs_or = '0; prev = sck_b; fin = 1'b0;
    while (!fin) begin
      cs_or |= ~cs_n_b;
      if (sck_b !== prev && ((sck_b !== pol) !== pha)) begin
        got = {mosi_b, got[15:1]};
        nbits++;
      end
      prev = sck_b;
      if (done_b === 1'b1 || lat >= 400) fin = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    rd = rdata_b;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cs_n_a !== 4'hF) begin failures++; $display("FAIL reset_cs_n_a got=%h exp=f", cs_n_a); end
    checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL reset_sck_a got=%b exp=0", sck_a); end
    checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL reset_mosi_a got=%b exp=0", mosi_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_a, done_a); end
    checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata_a got=%h exp=00", rdata_a); end
    checks++; if (cs_n_b !== 3'b111 || rdata_b !== 16'h0) begin failures++; $display("FAIL reset_b got=%b/%h exp=111/0000", cs_n_b, rdata_b); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loop();
    int lat, nb, rs; logic [7:0] rd, got; logic b1; logic [3:0] cso;
    xfer_a(8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (lat != LAT_A) begin failures++; $display("FAIL m0_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL m0_busy_after_accept got=%b exp=1", b1); end
    checks++; if (rs != 8) begin failures++; $display("FAIL m0_sck_rises got=%0d exp=8", rs); end
    checks++; if (cso !== 4'b0001) begin failures++; $display("FAIL m0_cs_low got=%b exp=0001", cso); end
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL m0_rdata got=%h exp=a5", rd); end
    checks++; if (got !== 8'hA5 || nb != 8) begin failures++; $display("FAIL m0_mosi_seq got=%h/%0d exp=a5/8", got, nb); end
    checks++; if (busy_a !== 1'b0 || cs_n_a !== 4'hF) begin failures++; $display("FAIL m0_done_cycle busy=%b cs_n=%h exp=0/f", busy_a, cs_n_a); end
    checks++; if (mosi_a !== 1'b1) begin failures++; $display("FAIL m0_mosi_hold got=%b exp=1", mosi_a); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL m0_done_width got=%b exp=0", done_a); end
    checks++; if (rdata_a !== 8'hA5) begin failures++; $display("FAIL m0_rdata_hold got=%h exp=a5", rdata_a); end
  endtask

  task automatic test_mode3_slave();
    int lat, nb, rs; logic [7:0] rd, got; logic b1; logic [3:0] cso;
    xfer_a(8'hF1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h3C, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL m3_rdata got=%h exp=3c", rd); end
    checks++; if (got !== 8'hF1) begin failures++; $display("FAIL m3_slave_rx got=%h exp=f1", got); end
    checks++; if (lat != LAT_A) begin failures++; $display("FAIL m3_latency got=%0d exp=%0d", lat, LAT_A); end
    repeat (5) @(negedge clk);
    checks++; if (sck_a !== 1'b1) begin failures++; $display("FAIL m3_sck_idle got=%b exp=1", sck_a); end
  endtask

  task automatic test_cs_select();
    int lat, nb, rs; logic [7:0] rd, got, td; logic b1; logic [3:0] cso;
    logic [15:0] rdb, gotb, tdb; logic [2:0] csb;
    td = 8'($urandom);
    xfer_a(td, 1'b0, 1'b1, 2'd2, 1'b1, 8'h00, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (cso !== 4'b0100) begin failures++; $display("FAIL cs2_lines got=%b exp=0100", cso); end
    checks++; if (rd !== td) begin failures++; $display("FAIL cs2_rdata got=%h exp=%h", rd, td); end
    tdb = 16'($urandom);
    xfer_b(tdb, 1'b0, 1'b0, 2'd3, lat, rdb, gotb, nb, csb);
    checks++; if (csb !== 3'b000) begin failures++; $display("FAIL cs_oor_lines got=%b exp=000", csb); end
    checks++; if (lat != LAT_B) begin failures++; $display("FAIL cs_oor_done got=%0d exp=%0d", lat, LAT_B); end
    checks++; if (rdb !== tdb) begin failures++; $display("FAIL cs_oor_rdata got=%h exp=%h", rdb, tdb); end
  endtask

  task automatic test_start_ignored();
    int lat, nb, rs, extra; logic [7:0] rd, got, td; logic b1; logic [3:0] cso;
    td = 8'($urandom);
    xfer_a(td, 1'b0, 1'b0, 2'd1, 1'b1, 8'h00, 1'b0, 10, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (rd !== td) begin failures++; $display("FAIL ign_rdata got=%h exp=%h", rd, td); end
    checks++; if (lat != LAT_A) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", lat, LAT_A); end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ign_extra_activity got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, nb, rs; logic [7:0] rd, got, t1, t2; logic b1; logic [3:0] cso;
    t1 = 8'($urandom); t2 = ~t1;
    xfer_a(t1, 1'b0, 1'b0, 2'd3, 1'b1, 8'h00, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (cs_n_a !== 4'hF) begin failures++; $display("FAIL b2b_cs_gap got=%h exp=f", cs_n_a); end
    xfer_a(t2, 1'b1, 1'b0, 2'd3, 1'b1, 8'h00, 1'b1, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (lat != LAT_A) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (rd !== t2 || cso !== 4'b1000) begin failures++; $display("FAIL b2b_second got=%h/%b exp=%h/1000", rd, cso, t2); end
  endtask

  task automatic test_reset_mid();
    int lat, nb, rs; logic [7:0] rd, got, td; logic b1; logic [3:0] cso;
    xfer_a(8'h5A, 1'b0, 1'b0, 2'd1, 1'b1, 8'h00, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rst_pre_rdata got=%h exp=5a", rd); end
    xfer_a(8'($urandom), 1'b0, 1'b0, 2'd1, 1'b1, 8'h00, 1'b0, 0, 3, lat, rd, b1, got, nb, rs, cso);
    checks++; if (nb != 3 || busy_a !== 1'b1) begin failures++; $display("FAIL rst_mid_reach bits=%0d busy=%b exp=3/1", nb, busy_a); end
    reset = 1'b0;
    #1;
    checks++; if (cs_n_a !== 4'hF || sck_a !== 1'b0) begin failures++; $display("FAIL rst_mid_pins got=%h/%b exp=f/0", cs_n_a, sck_a); end
    checks++; if (busy_a !== 1'b0 || rdata_a !== 8'h00) begin failures++; $display("FAIL rst_mid_state got=%b/%h exp=0/00", busy_a, rdata_a); end
    @(negedge clk);
    reset = 1'b1;
    td = 8'($urandom);
    xfer_a(td, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
    checks++; if (rd !== td || lat != LAT_A) begin failures++; $display("FAIL rst_recover got=%h/%0d exp=%h/%0d", rd, lat, td, LAT_A); end
  endtask

  task automatic test_lsb16();
    int lat, nb; logic [15:0] rd, got; logic [2:0] cso;
    xfer_b(16'h1234, 1'b0, 1'b0, 2'd0, lat, rd, got, nb, cso);
    checks++; if (lat != LAT_B) begin failures++; $display("FAIL lsb_latency got=%0d exp=%0d", lat, LAT_B); end
    checks++; if (got !== 16'h1234 || nb != 16) begin failures++; $display("FAIL lsb_mosi_order got=%h/%0d exp=1234/16", got, nb); end
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL lsb_rdata got=%h exp=1234", rd); end
    checks++; if (cso !== 3'b001) begin failures++; $display("FAIL lsb_cs got=%b exp=001", cso); end
  endtask

  task automatic test_random();
    int lat, nb, rs; logic [7:0] rd, got, td, sw; logic b1, pol, pha, lp; logic [3:0] cso; logic [1:0] sel;
    logic [15:0] rdb, gotb, tdb; logic [2:0] csb;
    for (int i = 0; i < 10; i++) begin
      td = 8'($urandom); sw = 8'($urandom); pol = 1'($urandom); pha = 1'($urandom);
      lp = 1'($urandom); sel = 2'($urandom_range(0, 3));
      xfer_a(td, pol, pha, sel, lp, sw, 1'b0, 0, 0, lat, rd, b1, got, nb, rs, cso);
      checks++; if (rd !== (lp ? td : sw)) begin failures++; $display("FAIL rnd_a_rdata[%0d] got=%h exp=%h", i, rd, lp ? td : sw); end
      checks++; if (got !== td || lat != LAT_A) begin failures++; $display("FAIL rnd_a_mosi[%0d] got=%h/%0d exp=%h/%0d", i, got, lat, td, LAT_A); end
      checks++; if (cso !== (4'b0001 << sel) || sck_a !== pol) begin failures++; $display("FAIL rnd_a_pins[%0d] got=%b/%b exp=%b/%b", i, cso, sck_a, 4'b0001 << sel, pol); end
    end
    for (int i = 0; i < 4; i++) begin
      tdb = 16'($urandom); pol = 1'($urandom); pha = 1'($urandom); sel = 2'($urandom_range(0, 2));
      xfer_b(tdb, pol, pha, sel, lat, rdb, gotb, nb, csb);
      checks++; if (rdb !== tdb || gotb !== tdb) begin failures++; $display("FAIL rnd_b_data[%0d] got=%h/%h exp=%h", i, rdb, gotb, tdb); end
      checks++; if (lat != LAT_B || csb !== (3'b001 << sel)) begin failures++; $display("FAIL rnd_b_ctl[%0d] got=%0d/%b exp=%0d/%b", i, lat, csb, LAT_B, 3'b001 << sel); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_loop();
    test_mode3_slave();
    test_cs_select();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_lsb16();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
